// File: rtl/xor32_stream_descrambler.sv
// ---------------------------------------------------------------------------
// xor32_stream_descrambler
//   Receive-side additive descrambler. Each accepted 32-bit word is XORed with
//   the current LFSR keystream word, then the LFSR advances 32 steps in one
//   cycle. Registered output, one-cycle latency, one word per clock.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   seed_load  one-cycle pulse: load seed into the LFSR (zero maps to 1)
//   seed       new LFSR seed
//   descr_en   1 = descramble, 0 = bypass (sampled on the accept cycle)
//   in_valid / in_ready / in_data     upstream valid/ready word port
//   out_valid / out_ready / out_data  downstream valid/ready word port
//   word_cnt   words accepted with descr_en=1
//
// Configuration
//   XOR_DESCR_WORDCNT_EN  defined: 16-bit wrapping word counter, cleared by
//                         reset and seed_load. Undefined: word_cnt tied to 0.
// ---------------------------------------------------------------------------
module xor32_stream_descrambler #(
    parameter logic [31:0] TAPS      = 32'h8020_0003,
    parameter logic [31:0] SEED_INIT = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_load,
    input  logic [31:0] seed,
    input  logic        descr_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] word_cnt
);

    logic [31:0] lfsr;
    logic [31:0] lfsr_adv;
    logic        accept;

    // 32 Fibonacci steps unrolled into one combinational cone.
    function automatic logic [31:0] adv32(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int i = 0; i < 32; i++)
            t = {t[30:0], ^(t & TAPS)};
        return t;
    endfunction

    assign lfsr_adv = adv32(lfsr);

    // rst_n gates ready combinationally so nothing is taken during reset;
    // seed_load blocks a word so the new seed applies to the next one cleanly.
    assign in_ready = rst_n & ~seed_load & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr      <= SEED_INIT;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
        end else begin
            if (seed_load)
                lfsr <= (seed == 32'h0) ? 32'h1 : seed;
            else if (accept && descr_en)
                lfsr <= lfsr_adv;

            if (accept) begin
                out_data  <= in_data ^ (descr_en ? lfsr : 32'h0);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef XOR_DESCR_WORDCNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || seed_load)
            cnt <= 16'h0;
        else if (accept && descr_en)
            cnt <= cnt + 16'h1;
    end

    assign word_cnt = cnt;
`else
    assign word_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_xor32_stream_descrambler.sv
module tb_xor32_stream_descrambler;

    localparam logic [31:0] TAPS      = 32'h8020_0003;
    localparam logic [31:0] SEED_INIT = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst_n, seed_load, descr_en, in_valid, out_ready;
    logic [31:0] seed, in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [15:0] word_cnt;

    xor32_stream_descrambler #(.TAPS(TAPS), .SEED_INIT(SEED_INIT)) dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .descr_en(descr_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Reference model: keystream as a bit sequence from the spec's step rule,
    // output side as a queue of expected words.
    logic [31:0] m_lfsr;
    logic [31:0] m_last;
    logic [31:0] q[$];
    int          m_cnt;
    int          n_acc, n_drn;

    function automatic logic [31:0] m_step32(input logic [31:0] s);
        logic [31:0] t = s;
        for (int k = 0; k < 32; k++) begin
            logic b = ^(t & TAPS);
            t = (t << 1) | {31'h0, b};
        end
        return t;
    endfunction

    // One clock: compare at the negedge, update model for the coming edge,
    // return at posedge+1 ready for new inputs.
    task automatic cyc();
        logic exp_rdy, acc;
        #4;
        exp_rdy = rst_n && !seed_load && (q.size() == 0 || out_ready);
        chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
        chk("out_valid", {31'h0, out_valid}, {31'h0, q.size() != 0});
        if (q.size() != 0) chk("out_data", out_data, q[0]);
        else               chk("out_hold", out_data, m_last);
        chk("word_cnt", {16'h0, word_cnt}, m_cnt[31:0] & 32'hFFFF);
        if (!rst_n) begin
            q.delete();
            m_lfsr = SEED_INIT; m_last = 0; m_cnt = 0;
        end else begin
            acc = in_valid && exp_rdy;
            if (q.size() != 0 && out_ready) begin q.pop_front(); n_drn++; end
            if (acc) begin
                m_last = in_data ^ (descr_en ? m_lfsr : 32'h0);
                q.push_back(m_last);
                n_acc++;
            end
            if (seed_load) begin
                m_lfsr = (seed == 0) ? 32'h1 : seed;
                m_cnt  = 0;
            end else if (acc && descr_en) begin
                m_lfsr = m_step32(m_lfsr);
`ifdef XOR_DESCR_WORDCNT_EN
                m_cnt  = (m_cnt + 1) % 65536;
`endif
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        seed_load = 0; in_valid = 0; out_ready = 1;
    endtask

    logic [31:0] k0, held;

    initial begin
        rst_n = 0; seed_load = 0; seed = 0; descr_en = 1;
        in_valid = 0; in_data = 0; out_ready = 1;
        m_lfsr = SEED_INIT; m_last = 0; m_cnt = 0; n_acc = 0; n_drn = 0;
        @(posedge clk); #1;

        // 1: reset state
        cyc(); cyc();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        rst_n = 1;
        #1 chk("rdy_after_rst", {31'h0, in_ready}, 32'h1);

        // 2: first word uses keystream 1
        in_valid = 1; in_data = 32'hFFFF_FFFF; descr_en = 1;
        cyc();
        chk("t2_data", out_data, 32'hFFFF_FFFE);
        chk("t2_valid", {31'h0, out_valid}, 32'h1);
        // next word with in_data=0 exposes adv32(1)
        in_data = 32'h0;
        cyc();
        chk("t2_adv", out_data, m_step32(32'h1));
        idle(); cyc();

        // 3: seed loads
        seed_load = 1; seed = 32'h0; cyc();
        seed_load = 0; in_valid = 1; in_data = 32'h0; cyc();
        chk("t3_zero_seed", out_data, 32'h0000_0001);
        idle(); seed_load = 1; seed = 32'hA5A5_A5A5; cyc();
        seed_load = 0; in_valid = 1; in_data = 32'hA5A5_A5A5; cyc();
        chk("t3_seed_a5", out_data, 32'h0);
        idle(); cyc();

        // 4: back-pressure
        in_valid = 1; in_data = 32'h0; out_ready = 0; cyc();
        held = out_data; k0 = m_lfsr;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_stall_rdy", {31'h0, in_ready}, 32'h0);
            chk("t4_stall_data", out_data, held);
        end
        out_ready = 1; in_data = 32'h0; cyc();
        chk("t4_one_adv", out_data, k0);
        idle(); cyc();

        // 4: random burst
        n_acc = 0; n_drn = 0;
        for (int i = 0; i < 1000 && n_acc < 100; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            descr_en  = ($urandom_range(0, 4) != 0);
            seed_load = ($urandom_range(0, 40) == 0);
            seed      = $urandom;
            in_data   = $urandom;
            cyc();
        end
        idle(); descr_en = 1;
        for (int i = 0; i < 10 && q.size() != 0; i++) cyc();
        chk("t4_burst_cnt", n_acc, 100);
        chk("t4_no_drop", n_drn, n_acc);

        // 5: bypass leaves LFSR untouched
        k0 = m_lfsr;
        in_valid = 1; descr_en = 0; in_data = 32'h1234_5678; cyc();
        chk("t5_bypass", out_data, 32'h1234_5678);
        descr_en = 1; in_data = 32'h0; cyc();
        chk("t5_key_kept", out_data, k0);
        idle(); cyc();

        // 6: word counter wrap
        seed_load = 1; seed = 32'h1; cyc();
        seed_load = 0; in_valid = 1; descr_en = 1;
        for (int i = 0; i < 65537; i++) begin
            in_data = $urandom;
            cyc();
        end
        idle(); cyc();
`ifdef XOR_DESCR_WORDCNT_EN
        chk("t6_wrap", {16'h0, word_cnt}, 32'h1);
`else
        chk("t6_tied", {16'h0, word_cnt}, 32'h0);
`endif
        seed_load = 1; seed = 32'h1234; cyc();
        chk("t6_clear", {16'h0, word_cnt}, 32'h0);
        idle(); cyc();

        // reset mid-transfer discards held word
        in_valid = 1; out_ready = 0; in_data = 32'hDEAD_BEEF; cyc();
        rst_n = 0; in_valid = 0; cyc();
        chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_mid_data", out_data, 32'h0);
        rst_n = 1; out_ready = 1; cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
